// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed 7-segment display driver. Scans NUM_DIGITS
//                hex digits, double-buffers the displayed value so updates
//                only take effect at frame boundaries, and supports
//                leading-zero blanking and per-digit blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_blk_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_div_w-1:0]    c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [c_blk_w-1:0]    c_blk_last = c_blk_w'(BLINK_FRAMES - 1);

  // XOR masks that turn active-high internal values into pin polarity;
  // they are also the "everything off" pin levels.
  localparam logic [6:0]            c_seg_off  = {7{SEG_ACTIVE_LOW}};
  localparam logic                  c_dp_off   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] c_sel_off  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  // Active-high glyphs ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [c_div_w-1:0]      r_div;
  logic [c_idx_w-1:0]      r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_active_val;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic [c_blk_w-1:0]      r_blk_cnt;
  logic                    r_blk_phase;
  logic                    r_frame_q;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_frame_done;

  logic                    w_tc;
  logic                    w_frame;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic                    w_blink_bit;
  logic                    w_lz_blank;
  logic                    w_upper_zero;
  logic                    w_blank;
  logic [6:0]              w_seg_hi;
  logic                    w_dp_hi;
  logic [NUM_DIGITS-1:0]   w_sel_hi;

  assign w_tc    = (r_div == c_div_last);
  assign w_frame = w_tc && (r_idx == c_idx_last);

  // Per-digit dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tc) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Scan index steps once per dwell period and wraps each frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_tc) begin
      r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
    end
  end

  // Shadow capture; a load on a boundary cycle keeps pending set because
  // the commit on that same edge uses the previous shadow contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (load) begin
        r_shadow_val <= value_in;
        r_shadow_dp  <= dp_in;
        r_pending    <= 1'b1;
      end else if (w_frame) begin
        r_pending    <= 1'b0;
      end
    end
  end

  // Displayed value only changes at a frame boundary, so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_val <= '0;
      r_active_dp  <= '0;
    end else if (w_frame && r_pending) begin
      r_active_val <= r_shadow_val;
      r_active_dp  <= r_shadow_dp;
    end
  end

  // Frame counter for the blink phase, toggling every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt   <= '0;
      r_blk_phase <= 1'b0;
    end else if (w_frame) begin
      if (r_blk_cnt == c_blk_last) begin
        r_blk_cnt   <= '0;
        r_blk_phase <= ~r_blk_phase;
      end else begin
        r_blk_cnt   <= r_blk_cnt + 1'b1;
      end
    end
  end

  // Pick the current digit's data and evaluate leading-zero blanking by
  // walking from the most significant digit downwards
  always_comb begin
    w_nib        = 4'h0;
    w_dp_bit     = 1'b0;
    w_blink_bit  = 1'b0;
    w_lz_blank   = 1'b0;
    w_upper_zero = 1'b1;
    w_sel_hi     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero && (r_active_val[i*4 +: 4] == 4'h0);
      if (r_idx == c_idx_w'(i)) begin
        w_nib       = r_active_val[i*4 +: 4];
        w_dp_bit    = r_active_dp[i];
        w_blink_bit = blink_en[i];
        w_lz_blank  = blank_lz && (i != 0) && w_upper_zero;
        w_sel_hi[i] = 1'b1;
      end
    end
  end

  assign w_blank  = w_lz_blank || (r_blk_phase && w_blink_bit);
  assign w_seg_hi = w_blank ? 7'h00 : f_glyph(w_nib);
  assign w_dp_hi  = !w_blank && w_dp_bit;

  // Output registers; frame_done is delayed one extra stage so it lines up
  // with the first registered cycle of digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= c_seg_off;
      r_dp         <= c_dp_off;
      r_sel        <= c_sel_off;
      r_frame_q    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_hi ^ c_seg_off;
      r_dp         <= w_dp_hi ^ c_dp_off;
      r_sel        <= w_sel_hi ^ c_sel_off;
      r_frame_q    <= w_frame;
      r_frame_done <= r_frame_q;
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign digit_sel  = r_sel;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver using a
//                frame-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int DV = 4;
  localparam int BF = 2;
  localparam int FL = N * DV;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = '0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS    (N),
    .CLK_DIV       (DV),
    .BLINK_FRAMES  (BF),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value_in  (value_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame, completed frame count,
  // and the two value buffers
  int          m_pos;
  int          m_frames;
  bit          m_fresh;
  logic [15:0] m_act_v, m_sh_v;
  logic [3:0]  m_act_dp, m_sh_dp;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos    = 0;
    m_frames = 0;
    m_fresh  = 1'b1;
    m_act_v  = '0;
    m_sh_v   = '0;
    m_act_dp = '0;
    m_sh_dp  = '0;
    m_pend   = 1'b0;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_seg"}, 32'(seg_out), 32'h7F);
    check({tag, "_dp"},  32'(dp_out), 32'h1);
    check({tag, "_sel"}, 32'(digit_sel), 32'hF);
    check({tag, "_fd"},  32'(frame_done), 32'h0);
  endtask

  // One clock: drive inputs, predict outputs after the edge, compare, advance model
  task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d);
    int         idx;
    bit         phase;
    bit         blank;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_sel;
    logic       e_fd;
    @(negedge clk);
    load     = ld;
    value_in = v;
    dp_in    = d;
    idx   = m_pos / DV;
    phase = ((m_frames / BF) % 2) == 1;
    blank = (phase && blink_en[idx]) ||
            (blank_lz && idx != 0 && (m_act_v >> (4 * idx)) == 16'h0);
    e_seg = blank ? 7'h7F : ~GLYPH[m_act_v[4*idx +: 4]];
    e_dp  = blank ? 1'b1 : ~m_act_dp[idx];
    e_sel = ~(4'(1 << idx));
    e_fd  = (m_pos == 0) && !m_fresh;
    @(posedge clk);
    #1;
    check("seg", 32'(seg_out), 32'(e_seg));
    check("dp", 32'(dp_out), 32'(e_dp));
    check("sel", 32'(digit_sel), 32'(e_sel));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    if (m_pos == FL - 1) begin
      if (m_pend) begin
        m_act_v  = m_sh_v;
        m_act_dp = m_sh_dp;
        m_pend   = 1'b0;
      end
      m_frames++;
    end
    if (ld) begin
      m_sh_v  = v;
      m_sh_dp = d;
      m_pend  = 1'b1;
    end
    m_pos   = (m_pos + 1) % FL;
    m_fresh = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FL && m_pos != target; i++) tick(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_off(tag);
    @(posedge clk);
    #1;
    check_off({tag, "_held"});
    release_reset();
  endtask

  initial begin
    model_reset();
    #12;
    check_off("reset");
    release_reset();

    // First edge after reset shows '0' on digit 0
    tick(1'b0, 16'h0, 4'h0);
    check("first_seg", 32'(seg_out), 32'b1000000);
    check("first_sel", 32'(digit_sel), 32'b1110);

    // Mid-frame load, then another mid-frame load
    run_to(6);
    tick(1'b1, 16'h12AF, 4'b0000);
    idle(2 * FL);
    run_to(9);
    tick(1'b1, 16'h3C4D, 4'b1010);
    idle(2 * FL);

    // Leading-zero blanking
    blank_lz = 1'b1;
    tick(1'b1, 16'h0050, 4'b0000);
    idle(2 * FL);
    tick(1'b1, 16'h0000, 4'b0000);
    idle(2 * FL);
    tick(1'b1, 16'h0000, 4'b0100);
    idle(2 * FL);
    blank_lz = 1'b0;

    // Load on the boundary cycle followed by a second load in the next frame
    run_to(FL - 1);
    tick(1'b1, 16'hAAAA, 4'b0011);
    idle(5);
    tick(1'b1, 16'h5555, 4'b1100);
    idle(2 * FL);

    // Several loads in one frame: last one wins
    run_to(1);
    tick(1'b1, 16'h1111, 4'h1);
    tick(1'b1, 16'h2222, 4'h2);
    idle(3);
    tick(1'b1, 16'h9876, 4'h4);
    idle(2 * FL);

    // Blinking from a fresh reset so frame numbering starts at 0
    mid_reset("rst_blink");
    blink_en = 4'b0001;
    tick(1'b0, 16'h0, 4'h0);
    tick(1'b1, 16'h4321, 4'b1111);
    idle(7 * FL);
    blink_en = 4'b0000;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ((i % 64) == 0) begin
        blank_lz = 1'($urandom);
        blink_en = 4'($urandom);
      end
      if ($urandom_range(0, 5) == 0)
        tick(1'b1, (($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom)),
             4'($urandom));
      else
        tick(1'b0, 16'($urandom), 4'($urandom));
    end
    blank_lz = 1'b0;
    blink_en = 4'b0000;

    // Reset mid-frame with a pending load discards it
    run_to(5);
    tick(1'b1, 16'hBEEF, 4'hF);
    idle(2);
    mid_reset("rst_pend");
    tick(1'b0, 16'h0, 4'h0);
    check("post_rst_seg", 32'(seg_out), 32'b1000000);
    check("post_rst_sel", 32'(digit_sel), 32'b1110);
    check("post_rst_dp", 32'(dp_out), 32'h1);
    idle(3 * FL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
